// File: rtl/icache_pkg.sv
// Shared sizing, derived address-field widths and FSM state type for the
// direct-mapped instruction cache.
package icache_pkg;
  localparam int NUM_LINES = 8;
  localparam int WORDS_PER = 4;
  localparam int ADDR_BITS = 10;

  localparam int IDX_W   = $clog2(NUM_LINES);
  localparam int WORD_W  = $clog2(WORDS_PER);
  localparam int TAG_W   = ADDR_BITS - IDX_W - WORD_W - 2;
  localparam int BLK_W   = 32 * WORDS_PER;
  localparam int BADDR_W = TAG_W + IDX_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;
endpackage

// File: rtl/instruction_cache_if.sv
// Block-read bus between the instruction cache (master) and the
// block-organised instruction memory (slave).
interface instruction_cache_if;
  import icache_pkg::*;

  logic               mem_read;
  logic [BADDR_W-1:0] mem_address;
  logic [BLK_W-1:0]   mem_readdata;
  logic               mem_busywait;

  modport master (output mem_read, output mem_address,
                  input  mem_readdata, input mem_busywait);
  modport slave  (input  mem_read, input mem_address,
                  output mem_readdata, output mem_busywait);
endinterface

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the cache lines: one write port, combinational
// read of the indexed line and tag compare.
module icache_line_array
  import icache_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic [IDX_W-1:0]   rd_index,
  input  logic [TAG_W-1:0]   rd_tag,
  output logic [BLK_W-1:0]   rd_block,
  output logic               hit,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [BLK_W-1:0]   wr_block
);
  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
  logic [BLK_W-1:0]     data_arr [NUM_LINES];

  // Only valid bits are reset; stale tag/data are masked by valid=0.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      tag_arr[wr_index]  <= wr_tag;
      data_arr[wr_index] <= wr_block;
    end
  end

  assign rd_block = data_arr[rd_index];
  assign hit      = valid[rd_index] && (tag_arr[rd_index] == rd_tag);
endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hit, stalls the CPU
// with BUSYWAIT while a 16-byte block is fetched from instruction memory.
//
// state    | meaning
// IDLE     | serving hits; a miss latches the block address
// MEM_READ | block read outstanding, waiting for mem_busywait to fall
// UPDATE   | writing the registered block into the line
module instruction_cache
  import icache_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic [31:0]         PC,
  output logic [31:0]         INSTRUCTION,
  output logic                BUSYWAIT,
  instruction_cache_if.master mem
);
  state_t             state, state_nx;
  logic [BADDR_W-1:0] req_addr;
  logic [BLK_W-1:0]   fill_buf;
  logic [BLK_W-1:0]   rd_block;
  logic               hit;
  logic               wr_en;

  logic [TAG_W-1:0]   pc_tag;
  logic [IDX_W-1:0]   pc_idx;
  logic [WORD_W-1:0]  pc_word;
  logic               unused_pc_bits;

  assign pc_tag  = PC[ADDR_BITS-1 -: TAG_W];
  assign pc_idx  = PC[ADDR_BITS-TAG_W-1 -: IDX_W];
  assign pc_word = PC[3:2];
  // Upper PC bits alias into the 1 KiB space; byte offset is ignored.
  assign unused_pc_bits = ^{PC[31:ADDR_BITS], PC[1:0]};

  icache_line_array u_lines (
    .CLK      (CLK),
    .RESET    (RESET),
    .rd_index (pc_idx),
    .rd_tag   (pc_tag),
    .rd_block (rd_block),
    .hit      (hit),
    .wr_en    (wr_en),
    .wr_index (req_addr[IDX_W-1:0]),
    .wr_tag   (req_addr[BADDR_W-1 -: TAG_W]),
    .wr_block (fill_buf)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      req_addr <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && !hit) begin
        req_addr <= {pc_tag, pc_idx};
      end
    end
  end

  // Block is taken on the last MEM_READ cycle and written during UPDATE.
  always_ff @(posedge CLK) begin
    if (state == MEM_READ && !mem.mem_busywait) begin
      fill_buf <= mem.mem_readdata;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (!hit) state_nx = MEM_READ;
      MEM_READ: if (!mem.mem_busywait) state_nx = UPDATE;
      UPDATE:   state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem.mem_read = 1'b0;
    BUSYWAIT     = 1'b1;
    wr_en        = 1'b0;
    case (state)
      IDLE:     BUSYWAIT = ~hit;
      MEM_READ: mem.mem_read = 1'b1;
      UPDATE:   wr_en = 1'b1;
      default:  BUSYWAIT = 1'b1;
    endcase
  end

  assign mem.mem_address = req_addr;
  assign INSTRUCTION     = rd_block[32*pc_word +: 32];
endmodule
